// File: rtl/div.sv
// Sequential signed divider (DIV semantics) for the multicycle MIPS core.
// Restoring division that produces one quotient bit per clock.
// The quotient goes to lo and the remainder goes to hi.
// Both results truncate toward zero, and the remainder takes the sign of the dividend.
//
// Ports:
//   Clock     rising-edge clock
//   Reset     synchronous, active-high reset (clears everything)
//   load      start request, sampled only in IDLE
//   dividendo dividend (rs), two's complement, sampled with load
//   divisor   divisor (rt), two's complement, sampled with load
//   hi        remainder, registered; updated only when the FIX state completes
//   lo        quotient, registered; updated only when the FIX state completes
//   busy      high whenever the FSM is not IDLE
//   done      one-cycle completion pulse (DONE state)
//   divzero   division-by-zero flag; held until the next accepted load
//   counter   iteration count (debug)
module div #(
  parameter int WIDTH = 32
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] dividendo,
  input  logic signed [WIDTH-1:0] divisor,
  output logic        [WIDTH-1:0] hi,
  output logic        [WIDTH-1:0] lo,
  output logic                    busy,
  output logic                    done,
  output logic                    divzero,
  output logic        [5:0]       counter
);

  typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;

  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] a_reg;
  logic signed [WIDTH-1:0] b_reg;
  logic        [WIDTH-1:0] dmag;
  logic        [WIDTH-1:0] q;
  logic        [WIDTH:0]   r;
  logic                    qneg;
  logic                    rneg;

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q_step;

  // Two's-complement negate when neg is set, modulo 2^WIDTH. The magnitude
  // of the most negative value comes out as 2^(WIDTH-1), which is correct
  // when it is read as unsigned.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // One restoring step: shift {R,Q} left, then try to subtract the divisor magnitude.
  always_comb begin
    shifted = {r[WIDTH-1:0], q[WIDTH-1]};
    fits    = (shifted >= {1'b0, dmag});
    r_step  = fits ? (shifted - {1'b0, dmag}) : shifted;
    q_step  = {q[WIDTH-2:0], fits};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = (divisor == '0) ? DONE : PREP;
      PREP:    state_nxt = RUN;
      RUN:     if (counter == LAST) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state   <= IDLE;
      hi      <= '0;
      lo      <= '0;
      counter <= '0;
      divzero <= 1'b0;
      a_reg   <= '0;
      b_reg   <= '0;
      dmag    <= '0;
      q       <= '0;
      r       <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (load) begin
            if (divisor == '0) begin
              // hi/lo keep their previous values; only the flag reports the fault.
              divzero <= 1'b1;
            end else begin
              divzero <= 1'b0;
              a_reg   <= dividendo;
              b_reg   <= divisor;
            end
          end
        end
        PREP: begin
          q       <= cond_neg(a_reg, a_reg[WIDTH-1]);
          dmag    <= cond_neg(b_reg, b_reg[WIDTH-1]);
          qneg    <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1];
          rneg    <= a_reg[WIDTH-1];
          r       <= '0;
          counter <= '0;
        end
        RUN: begin
          r       <= r_step;
          q       <= q_step;
          counter <= counter + 6'd1;
        end
        FIX: begin
          // After WIDTH steps, R is less than |divisor|, so it fits in WIDTH bits.
          lo <= cond_neg(q, qneg);
          hi <= cond_neg(r[WIDTH-1:0], rneg);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
module tb_div;

  logic        Clock;
  logic        Reset;
  logic        load;
  logic [31:0] dividendo;
  logic [31:0] divisor;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        divzero;
  logic [5:0]  counter;

  int errors = 0;
  int checks = 0;

  div #(.WIDTH(32)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .load      (load),
    .dividendo (dividendo),
    .divisor   (divisor),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy),
    .done      (done),
    .divzero   (divzero),
    .counter   (counter)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference: signed division that truncates toward zero, done in 64 bits so
  // that -2^31 / -1 does not trap. The results are then wrapped to 32 bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa;
    longint sb;
    longint sq;
    longint sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sq = sa / sb;
    sr = sa % sb;
    q  = sq[31:0];
    r  = sr[31:0];
  endfunction

  // Entered about 1 time unit after a rising edge, with the DUT idle. This task
  // pulses load for one edge (edge k), then counts edges until done is seen.
  // lat is the number of edges after k. It then steps one more edge and
  // reports busy.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_after);
    load = 1'b1; dividendo = a; divisor = b;
    @(posedge Clock); #1;
    load = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge Clock); #1;
      lat++;
    end
    @(posedge Clock); #1;
    busy_after = busy;
  endtask

  task automatic test_reset;
    Reset = 1'b1; load = 1'b0; dividendo = '0; divisor = '0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi got=%h exp=0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo got=%h exp=0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL reset_divzero got=%b exp=0", divzero); end
    checks++; if (counter !== 6'd0) begin errors++; $display("FAIL reset_counter got=%0d exp=0", counter); end
  endtask

  task automatic test_basic;
    int lat;
    logic ba;
    run_op(32'd100, 32'd7, lat, ba);
    checks++; if (lat != 34) begin errors++; $display("FAIL basic_latency got=%0d exp=34", lat); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL basic_lo got=%h exp=0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL basic_hi got=%h exp=00000002", hi); end
    checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL basic_divzero got=%b exp=0", divzero); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got=%b exp=0", ba); end
  endtask

  task automatic test_signs;
    logic [31:0] ta [7] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF8, 32'h80000000,
                            32'h7FFFFFFF, 32'd0, 32'h80000000};
    logic [31:0] tb [7] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFF,
                            32'd1, 32'd5, 32'd1};
    logic [31:0] eq, er;
    int lat;
    logic ba;
    for (int i = 0; i < 7; i++) begin
      model(ta[i], tb[i], eq, er);
      run_op(ta[i], tb[i], lat, ba);
      checks++; if (lo !== eq) begin errors++; $display("FAIL sign_lo[%0d] got=%h exp=%h", i, lo, eq); end
      checks++; if (hi !== er) begin errors++; $display("FAIL sign_hi[%0d] got=%h exp=%h", i, hi, er); end
      checks++; if (lat != 34) begin errors++; $display("FAIL sign_latency[%0d] got=%0d exp=34", i, lat); end
      checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL sign_divzero[%0d] got=%b exp=0", i, divzero); end
    end
  endtask

  task automatic test_divzero;
    int lat;
    logic ba;
    run_op(32'd100, 32'd7, lat, ba);
    run_op(32'd5, 32'd0, lat, ba);
    checks++; if (lat != 0) begin errors++; $display("FAIL dz_latency got=%0d exp=0", lat); end
    checks++; if (divzero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", divzero); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL dz_hi_kept got=%h exp=00000002", hi); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL dz_lo_kept got=%h exp=0000000e", lo); end
    run_op(32'd9, 32'd3, lat, ba);
    checks++; if (divzero !== 1'b0) begin errors++; $display("FAIL dz_clear got=%b exp=0", divzero); end
    checks++; if (lo !== 32'd3) begin errors++; $display("FAIL dz_next_lo got=%h exp=00000003", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL dz_next_hi got=%h exp=0", hi); end
  endtask

  task automatic test_ignore_load;
    int lat;
    load = 1'b1; dividendo = 32'd100; divisor = 32'd7;
    @(posedge Clock); #1;
    load = 1'b0;
    lat = 0;
    repeat (9) begin @(posedge Clock); #1; lat++; end
    load = 1'b1; dividendo = 32'd50; divisor = 32'd5;
    @(posedge Clock); #1; lat++;
    load = 1'b0; dividendo = 32'd0; divisor = 32'd0;
    while (done !== 1'b1 && lat < 100) begin @(posedge Clock); #1; lat++; end
    checks++; if (lat != 34) begin errors++; $display("FAIL busyload_latency got=%0d exp=34", lat); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL busyload_lo got=%h exp=0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL busyload_hi got=%h exp=00000002", hi); end
    @(posedge Clock); #1;
  endtask

  task automatic test_reset_abort;
    int seen;
    int lat;
    logic ba;
    load = 1'b1; dividendo = 32'd100; divisor = 32'd7;
    @(posedge Clock); #1;
    load = 1'b0;
    repeat (14) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    Reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", done); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL abort_hilo got=%h/%h exp=0/0", hi, lo); end
    checks++; if (counter !== 6'd0) begin errors++; $display("FAIL abort_counter got=%0d exp=0", counter); end
    seen = 0;
    repeat (40) begin @(posedge Clock); #1; if (done === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_done got=%0d exp=0", seen); end
    run_op(32'd9, 32'd3, lat, ba);
    checks++; if (lo !== 32'd3 || hi !== 32'd0 || lat != 34) begin
      errors++; $display("FAIL abort_next got=%h/%h lat=%0d exp=3/0 lat=34", lo, hi, lat);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    int gap;
    load = 1'b1; dividendo = 32'd100; divisor = 32'd7;
    @(posedge Clock); #1;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin @(posedge Clock); #1; lat++; end
    checks++; if (lat != 34) begin errors++; $display("FAIL b2b_first_latency got=%0d exp=34", lat); end
    dividendo = 32'hFFFFFF9C; divisor = 32'd7;
    gap = 0;
    @(posedge Clock); #1; gap++;
    while (done !== 1'b1 && gap < 100) begin @(posedge Clock); #1; gap++; end
    load = 1'b0;
    checks++; if (gap != 36) begin errors++; $display("FAIL b2b_gap got=%0d exp=36", gap); end
    checks++; if (lo !== 32'hFFFFFFF2 || hi !== 32'hFFFFFFFE) begin
      errors++; $display("FAIL b2b_result got=%h/%h exp=fffffff2/fffffffe", lo, hi);
    end
    @(posedge Clock); #1;
  endtask

  task automatic test_random;
    logic [31:0] a, b, eq, er;
    int lat;
    logic ba;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      case (i % 3)
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 300));
        default: b = 32'(-int'($urandom_range(1, 300)));
      endcase
      if (b == 32'd0) b = 32'd1;
      model(a, b, eq, er);
      run_op(a, b, lat, ba);
      checks++; if (lo !== eq || hi !== er || lat != 34) begin
        errors++; $display("FAIL rand[%0d] %h/%h got=%h,%h lat=%0d exp=%h,%h lat=34", i, a, b, lo, hi, lat, eq, er);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signs;
    test_divzero;
    test_ignore_load;
    test_reset_abort;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
